pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
// - Central hazard/stall sequencer for the 5-stage LC-3b pipeline.
// - Drives load enables of IF/ID, ID/EX, EX/MEM, MEM/WB stage registers and the PC.
// - Injects bubbles and flushes, and holds off duplicate cache requests while waiting.
// - Resolves I-cache/D-cache wait, load-use hazard and taken-branch flush with fixed priority.
// PARAMETERS
// - REG_W   3   register-specifier width (lc3b_reg)
// - CNT_W  32   width of perf counters (used only with STALL_PERF_CNT_EN)
// PORTS
// - clk           in   1      clock, all state on rising edge
// - rst_n         in   1      asynchronous, active-low reset
// - imem_req      in   1      IF stage wants an instruction fetch this cycle
// - imem_resp     in   1      I-cache response (1-cycle pulse)
// - dmem_req      in   1      MEM stage valid and is LDR/STR/LDB/STB/LDI/STI
// - dmem_resp     in   1      D-cache response (1-cycle pulse)
// - id_src1       in   REG_W  ID-stage source register 1
// - id_src2       in   REG_W  ID-stage source register 2
// - id_src_use    in   2      [0]=src1 read, [1]=src2 read by ID instruction
// - ex_dest       in   REG_W  EX-stage destination register
// - ex_is_load    in   1      EX-stage instruction is a memory load
// - ex_valid      in   1      EX-stage valid bit
// - mem_br_taken  in   1      MEM stage resolved taken branch/JMP/JSR/TRAP (valid-qualified)
// - imem_read     out  1      gated I-cache read strobe
// - dmem_strobe   out  1      gated D-cache read/write strobe
// - load_pc       out  1      PC register load
// - load_if_id    out  1      IF/ID register load
// - load_id_ex    out  1      ID/EX register load
// - load_ex_mem   out  1      EX/MEM register load
// - load_mem_wb   out  1      MEM/WB register load
// - bubble_id_ex  out  1      force valid=0 into ID/EX on this load
// - flush         out  1      force valid=0 into IF/ID, ID/EX, EX/MEM on this load
// BEHAVIOUR
// - State: RUN or WAIT. Flags i_done and d_done record an early response while in WAIT.
// - i_pend = imem_req & ~imem_resp & ~i_done.
// - d_pend = dmem_req & ~dmem_resp & ~d_done.
// - mem_stall = i_pend | d_pend.
// - Transitions:
//   - RUN -> WAIT when mem_stall.
//   - WAIT -> RUN in the cycle mem_stall drops. All loads assert in that same cycle.
//   - Clear i_done/d_done on the WAIT->RUN edge.
// - In WAIT, an imem_resp with d_pend still set sets i_done. dmem_resp is handled symmetrically.
// - imem_read = imem_req & ~i_done.
// - dmem_strobe = dmem_req & ~d_done.
// - A completed access is never re-issued.
// - Priority, highest first:
//   1. mem_stall: all loads = 0, bubble_id_ex = 0, flush = 0.
//   2. mem_br_taken: all loads = 1, flush = 1 (bubble_id_ex = 0).
//   3. Load-use hazard: load_pc = load_if_id = 0, load_id_ex = 1 with bubble_id_ex = 1, load_ex_mem = load_mem_wb = 1.
//      - Hazard = ex_valid & ex_is_load & ((id_src_use[0] & id_src1 == ex_dest) | (id_src_use[1] & id_src2 == ex_dest)).
//   4. Otherwise all loads = 1.
// - Latency: a load-use stall lasts exactly 1 cycle. The bubble makes the hazard disappear next cycle.
// - A cache wait lasts until the last outstanding response, +0 cycles.
// - Same-cycle imem_resp and dmem_resp while both pending: leave WAIT that cycle.
// - Branch during a cache wait: the flush is deferred until the stall clears. mem_br_taken is held by the frozen EX/MEM.
// - Reset (rst_n low, asynchronous):
//   - State = RUN, flags = 0.
//   - All load_*, imem_read, dmem_strobe, bubble_id_ex and flush forced to 0 while rst_n is low.
//   - Counters = 0.
// - Reset mid-WAIT discards the flags. The first post-reset cycle re-issues any request.
// CONFIGURATION
// - STALL_PERF_CNT_EN defined: adds output ports perf_mem_stall (CNT_W), perf_lu_stall (CNT_W) and perf_flush (CNT_W).
//   - Each port increments once per cycle its condition wins priority.
//   - Each counter saturates at all-ones and does not wrap.
// - STALL_PERF_CNT_EN undefined: these ports and counters do not exist. All other behaviour is identical.
// TESTING
// - Fetch only, imem_resp 3 cycles after imem_req:
//   - load_pc = 0 for 3 cycles, 1 on the resp cycle.
//   - imem_read stays 1 throughout.
// - imem_req and dmem_req together, imem_resp at cycle 1, dmem_resp at cycle 4:
//   - imem_read = 0 in cycles 2-4.
//   - All loads 0 until cycle 4.
//   - All loads 1 at cycle 4.
// - ex_is_load = 1, ex_dest = 3, id_src1 = 3, id_src_use = 01:
//   - One cycle with load_pc = 0 and bubble_id_ex = 1.
//   - The next cycle is a normal advance.
// - mem_br_taken = 1 with no stall -> flush = 1 and all loads 1 for exactly one cycle.
// - mem_br_taken = 1 and load-use in the same cycle -> flush wins, bubble_id_ex = 0.
// - rst_n low during WAIT -> all outputs 0 immediately. After release, state is RUN and imem_read is re-asserted.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage LC-3b pipeline: cache waits, load-use bubbles, branch flush.
// Optional saturating perf counters are enabled by defining STALL_PERF_CNT_EN.
module pipeline_stall_ctrl #(
  parameter int REG_W = 3,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_req,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic [1:0]       id_src_use,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_is_load,
  input  logic             ex_valid,
  input  logic             mem_br_taken,
  output logic             imem_read,
  output logic             dmem_strobe,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             bubble_id_ex,
  output logic             flush
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_mem_stall,
  output logic [CNT_W-1:0] perf_lu_stall,
  output logic [CNT_W-1:0] perf_flush
`endif
);

  // state | meaning
  // RUN   | no cache access outstanding, pipeline advances or bubbles/flushes
  // WAIT  | frozen on at least one outstanding cache access
  typedef enum logic {RUN, WAIT} state_t;

  state_t state_q, state_d;
  logic   i_done_q, i_done_d;
  logic   d_done_q, d_done_d;
  logic   i_pend, d_pend, mem_stall, hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_done_q <= i_done_d;
      d_done_q <= d_done_d;
    end
  end

  always_comb begin
    i_pend    = imem_req & ~imem_resp & ~i_done_q;
    d_pend    = dmem_req & ~dmem_resp & ~d_done_q;
    mem_stall = i_pend | d_pend;
    hazard    = ex_valid & ex_is_load &
                ((id_src_use[0] & (id_src1 == ex_dest)) |
                 (id_src_use[1] & (id_src2 == ex_dest)));

    state_d  = state_q;
    i_done_d = i_done_q;
    d_done_d = d_done_q;

    case (state_q)
      RUN:  if (mem_stall) state_d = WAIT;
      WAIT: if (!mem_stall) begin
        state_d  = RUN;
        i_done_d = 1'b0;
        d_done_d = 1'b0;
      end
      default: state_d = RUN;
    endcase

    // Remember a response that lands while the other side still holds us frozen,
    // so that the finished access is not re-issued.
    if (mem_stall) begin
      if (imem_req & imem_resp & d_pend) i_done_d = 1'b1;
      if (dmem_req & dmem_resp & i_pend) d_done_d = 1'b1;
    end

    imem_read    = imem_req & ~i_done_q;
    dmem_strobe  = dmem_req & ~d_done_q;
    load_pc      = 1'b0;
    load_if_id   = 1'b0;
    load_id_ex   = 1'b0;
    load_ex_mem  = 1'b0;
    load_mem_wb  = 1'b0;
    bubble_id_ex = 1'b0;
    flush        = 1'b0;

    if (mem_stall) begin
      load_pc = 1'b0;
    end else if (mem_br_taken) begin
      load_pc     = 1'b1;
      load_if_id  = 1'b1;
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      flush       = 1'b1;
    end else if (hazard) begin
      load_id_ex   = 1'b1;
      bubble_id_ex = 1'b1;
      load_ex_mem  = 1'b1;
      load_mem_wb  = 1'b1;
    end else begin
      load_pc     = 1'b1;
      load_if_id  = 1'b1;
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
    end

    // Outputs are held quiet for the whole reset pulse, not just from the next edge.
    if (!rst_n) begin
      imem_read    = 1'b0;
      dmem_strobe  = 1'b0;
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      load_id_ex   = 1'b0;
      load_ex_mem  = 1'b0;
      load_mem_wb  = 1'b0;
      bubble_id_ex = 1'b0;
      flush        = 1'b0;
    end
  end

`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_mem_stall <= '0;
      perf_lu_stall  <= '0;
      perf_flush     <= '0;
    end else begin
      if (mem_stall && perf_mem_stall != '1)
        perf_mem_stall <= perf_mem_stall + CNT_W'(1);
      if (!mem_stall && mem_br_taken && perf_flush != '1)
        perf_flush <= perf_flush + CNT_W'(1);
      if (!mem_stall && !mem_br_taken && hazard && perf_lu_stall != '1)
        perf_lu_stall <= perf_lu_stall + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: per-cycle expected output vectors queued at drive time.
module tb_pipeline_stall_ctrl;

  localparam int REG_W = 3;
  localparam int CNT_W = 32;

  // load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, bubble_id_ex, flush
  localparam logic [6:0] L_STALL = 7'b0000000;
  localparam logic [6:0] L_RUN   = 7'b1111100;
  localparam logic [6:0] L_LU    = 7'b0011110;
  localparam logic [6:0] L_FL    = 7'b1111101;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             imem_req, imem_resp, dmem_req, dmem_resp;
  logic [REG_W-1:0] id_src1, id_src2, ex_dest;
  logic [1:0]       id_src_use;
  logic             ex_is_load, ex_valid, mem_br_taken;
  logic             imem_read, dmem_strobe, load_pc, load_if_id, load_id_ex;
  logic             load_ex_mem, load_mem_wb, bubble_id_ex, flush;
`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] perf_mem_stall, perf_lu_stall, perf_flush;
`endif

  logic [8:0] out_vec;
  logic [8:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .id_src1(id_src1), .id_src2(id_src2), .id_src_use(id_src_use),
    .ex_dest(ex_dest), .ex_is_load(ex_is_load), .ex_valid(ex_valid),
    .mem_br_taken(mem_br_taken),
    .imem_read(imem_read), .dmem_strobe(dmem_strobe), .load_pc(load_pc),
    .load_if_id(load_if_id), .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem),
    .load_mem_wb(load_mem_wb), .bubble_id_ex(bubble_id_ex), .flush(flush)
`ifdef STALL_PERF_CNT_EN
    ,
    .perf_mem_stall(perf_mem_stall), .perf_lu_stall(perf_lu_stall), .perf_flush(perf_flush)
`endif
  );

  assign out_vec = {imem_read, dmem_strobe, load_pc, load_if_id, load_id_ex,
                    load_ex_mem, load_mem_wb, bubble_id_ex, flush};

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b (ir ds pc ifid idex exmem memwb bub fl)", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got %b want <queued vector>", tag, out_vec);
    end else begin
      chk(tag, out_vec, exp_q.pop_front());
    end
  endtask

  // Drive one cycle of memory/branch inputs, queue its expectation, compare mid-cycle.
  task automatic step(input string tag, input logic ireq, input logic iresp,
                      input logic dreq, input logic dresp, input logic br,
                      input logic e_ir, input logic e_ds, input logic [6:0] e_l);
    imem_req     = ireq;
    imem_resp    = iresp;
    dmem_req     = dreq;
    dmem_resp    = dresp;
    mem_br_taken = br;
    exp_q.push_back({e_ir, e_ds, e_l});
    @(negedge clk);
    pop_chk(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic set_hz(input logic v, input logic ld, input logic [REG_W-1:0] d,
                        input logic [REG_W-1:0] s1, input logic [REG_W-1:0] s2,
                        input logic [1:0] u);
    ex_valid   = v;
    ex_is_load = ld;
    ex_dest    = d;
    id_src1    = s1;
    id_src2    = s2;
    id_src_use = u;
  endtask

  initial begin
    rst_n = 1'b0;
    imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0; mem_br_taken = 0;
    set_hz(0, 0, 0, 0, 0, 2'b00);
    @(posedge clk);
    #1;
    step("reset", 1, 0, 1, 0, 1, 0, 0, L_STALL);
    rst_n = 1'b1;
    step("idle", 0, 0, 0, 0, 0, 0, 0, L_RUN);

    // fetch only, response on the 4th cycle
    step("fetch_c0", 1, 0, 0, 0, 0, 1, 0, L_STALL);
    step("fetch_c1", 1, 0, 0, 0, 0, 1, 0, L_STALL);
    step("fetch_c2", 1, 0, 0, 0, 0, 1, 0, L_STALL);
    step("fetch_resp", 1, 1, 0, 0, 0, 1, 0, L_RUN);
    step("fetch_idle", 0, 0, 0, 0, 0, 0, 0, L_RUN);

    // I and D together: I answers at cycle 1, D at cycle 4
    step("dual_c0", 1, 0, 1, 0, 0, 1, 1, L_STALL);
    step("dual_c1", 1, 1, 1, 0, 0, 1, 1, L_STALL);
    step("dual_c2", 1, 0, 1, 0, 0, 0, 1, L_STALL);
    step("dual_c3", 1, 0, 1, 0, 0, 0, 1, L_STALL);
    step("dual_c4", 1, 0, 1, 1, 0, 0, 1, L_RUN);
    step("dual_after", 1, 1, 0, 0, 0, 1, 0, L_RUN);

    // D answers first
    step("dfirst_c0", 1, 0, 1, 0, 0, 1, 1, L_STALL);
    step("dfirst_c1", 1, 0, 1, 1, 0, 1, 1, L_STALL);
    step("dfirst_c2", 1, 1, 1, 0, 0, 1, 0, L_RUN);

    // both responses in the same cycle
    step("both_c0", 1, 0, 1, 0, 0, 1, 1, L_STALL);
    step("both_c1", 1, 1, 1, 1, 0, 1, 1, L_RUN);

    // load-use hazards
    set_hz(1, 1, 3'd3, 3'd3, 3'd0, 2'b01);
    step("lu_src1", 0, 0, 0, 0, 0, 0, 0, L_LU);
    set_hz(0, 1, 3'd3, 3'd3, 3'd0, 2'b01);
    step("lu_after", 0, 0, 0, 0, 0, 0, 0, L_RUN);
    set_hz(1, 1, 3'd5, 3'd1, 3'd5, 2'b10);
    step("lu_src2", 0, 0, 0, 0, 0, 0, 0, L_LU);
    set_hz(1, 1, 3'd5, 3'd5, 3'd2, 2'b10);
    step("lu_unused_src", 0, 0, 0, 0, 0, 0, 0, L_RUN);
    set_hz(1, 0, 3'd3, 3'd3, 3'd3, 2'b11);
    step("lu_not_load", 0, 0, 0, 0, 0, 0, 0, L_RUN);
    set_hz(1, 1, 3'd3, 3'd4, 3'd6, 2'b11);
    step("lu_no_match", 0, 0, 0, 0, 0, 0, 0, L_RUN);

    // branch flush
    set_hz(0, 0, 0, 0, 0, 2'b00);
    step("br_flush", 0, 0, 0, 0, 1, 0, 0, L_FL);
    step("br_after", 0, 0, 0, 0, 0, 0, 0, L_RUN);
    set_hz(1, 1, 3'd2, 3'd2, 3'd0, 2'b01);
    step("br_over_lu", 0, 0, 0, 0, 1, 0, 0, L_FL);
    step("lu_in_stall", 1, 0, 0, 0, 0, 1, 0, L_STALL);
    step("lu_stall_end", 1, 1, 0, 0, 0, 1, 0, L_LU);
    set_hz(0, 0, 0, 0, 0, 2'b00);

    // branch deferred behind a cache wait
    step("br_in_stall", 1, 0, 0, 0, 1, 1, 0, L_STALL);
    step("br_deferred", 1, 1, 0, 0, 1, 1, 0, L_FL);

    // reset in the middle of a wait with i_done already recorded
    step("rw_c0", 1, 0, 1, 0, 0, 1, 1, L_STALL);
    step("rw_c1", 1, 1, 1, 0, 0, 1, 1, L_STALL);
    imem_req = 1; imem_resp = 0; dmem_req = 1; dmem_resp = 0; mem_br_taken = 1;
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(9'b0);
    pop_chk("rst_in_wait");
    @(posedge clk);
    #1;
    exp_q.push_back(9'b0);
    pop_chk("rst_held");
    rst_n = 1'b1;
    step("rst_reissue", 1, 0, 1, 0, 0, 1, 1, L_STALL);
    step("rst_done", 1, 1, 1, 1, 0, 1, 1, L_RUN);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
